ca_row_streamer: RTL and testbench
==================================

# ca_row_streamer

Read-side companion to the 32-cell Rule 110 automaton core. Each time the core publishes a new generation, this block can snapshot the full row into a shadow register. It then serializes the snapshot onto an 8-bit valid/ready byte stream, so a host can observe every cell, not just the 16 cells wired to pins. It also provides generation counting, row decimation and overrun detection.

## Interface
Parameters:
- NUM_CELLS, 32, row width. Must be a multiple of 8 and at least 8. Bytes per row: NB = NUM_CELLS/8.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- row_in  input  NUM_CELLS  current generation from the automaton; bit i = cell i.
- row_valid  input  1  one-cycle pulse, one per new generation; row_in is valid in that cycle.
- decim  input  4  capture one row out of every decim+1 row_valid pulses.
- out_data  output  8  stream byte.
- out_valid  output  1  out_data holds a valid byte.
- out_ready  input  1  consumer accepts the byte. A transfer happens on a cycle where out_valid && out_ready.
- out_first  output  1  high with byte 0 of a row.
- out_last  output  1  high with byte NB-1 of a row.
- gen_count  output  16  number of row_valid pulses seen since reset; wraps modulo 2^16.
- overrun  output  1  sticky flag: a row selected for capture was dropped.

## Operation
- FSM states: IDLE and SEND. Registers: shadow[NUM_CELLS], byte index idx (0..NB-1), decimation counter dcnt[3:0].
- Every row_valid:
  - increments gen_count.
  - A row is *selected* when dcnt==0. On a selected row, dcnt reloads with decim. Otherwise dcnt decrements.
  - decim is sampled only at reload.
- IDLE + selected row:
  - shadow <= row_in; idx <= 0; go to SEND.
- SEND:
  - out_valid=1.
  - out_data = shadow[8*idx+7 : 8*idx]; byte 0 is cells 7..0 and goes first.
  - out_first = (idx==0); out_last = (idx==NB-1).
  - On a transfer with idx<NB-1: idx increments.
  - On a transfer with idx==NB-1: return to IDLE, unless the simultaneous-capture case below applies.
- Selected row in SEND, not on the final transfer cycle:
  - The row is dropped and overrun <= 1.
  - shadow and idx are unchanged; the current row completes intact.
- Selected row on the final transfer cycle (idx==NB-1 && out_ready):
  - The row is captured; stay in SEND with idx <= 0.
  - No overrun.
- Unselected rows never touch shadow and never set overrun.
- out_data, out_first and out_last are 0 whenever out_valid=0.

## Timing
- Reset values:
  - Outputs: out_valid=0, out_data=0, out_first=0, out_last=0, gen_count=0, overrun=0.
  - Internal: state=IDLE, dcnt=0 (so the first row after reset is selected), idx=0, shadow=0.
- Reset mid-frame: the next cycle shows out_valid=0 and the frame is abandoned. Reset has priority over a simultaneous row_valid.
- Latency: row_valid in cycle T gives out_valid=1 with byte 0 in cycle T+1.
- Throughput: with out_ready held high, NB consecutive cycles per row. Rows can stream back-to-back when row_valid pulses are spaced exactly NB cycles apart.
- Backpressure: while out_valid && !out_ready, out_data, out_first and out_last hold stable and idx does not advance. out_valid never drops mid-row except on reset.
- gen_count and overrun update in the cycle after the row_valid edge.
- gen_count wraps from 0xFFFF to 0x0000 with no flag.

## Test plan
- **Basic stream.** Reset, decim=0, out_ready=1, row_in=0xDEADBEEF with one row_valid. Required: bytes EF, BE, AD, DE in cycles T+1..T+4; out_first only on EF; out_last only on DE; gen_count=1; then out_valid=0.
- **Backpressure.** As above, but drop out_ready for 3 cycles while BE is presented. Required: BE held stable for 3 cycles; exactly 4 transfers total; no duplicated or skipped bytes.
- **Decimation.** decim=2, six row_valid pulses 10 cycles apart with rows 1..6 = 0x00000001..0x00000006. Required: only rows 1 and 4 are streamed; gen_count=6; overrun=0.
- **Overrun.** out_ready=0, row A captured, then a second row_valid with row B (decim=0). Required: overrun=1 and stays 1. After raising out_ready, exactly row A's 4 bytes are streamed, and B is not streamed.
- **Simultaneous events.** out_ready=1, row_valid pulses every 4 cycles with rows 0x11111111, 0x22222222. Required: 8 contiguous transfers (11,11,11,11,22,22,22,22) with out_valid continuously high; overrun=0.
- **Reset and wrap.**
  - Assert reset while idx=2. Required: next cycle out_valid=0, gen_count=0, overrun=0, and the next row streams from byte 0.
  - Drive 65536 row_valid pulses. Required: gen_count=0.

Source files
------------

// File: rtl/ca_row_streamer.sv
`default_nettype none
// ============================================================================
// Module      : ca_row_streamer
// Description : Snapshots selected automaton rows and streams them out as
//               valid/ready bytes, with generation count and overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ca_row_streamer #(
  parameter int NUM_CELLS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CELLS-1:0] row_in,
  input  logic                 row_valid,
  input  logic [3:0]           decim,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_first,
  output logic                 out_last,
  output logic [15:0]          gen_count,
  output logic                 overrun
);

  localparam int NB = NUM_CELLS / 8;
  localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NB - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [NUM_CELLS-1:0] shadow;
  logic [IDXW-1:0]      idx;
  logic [IDXW-1:0]      idx_nxt;
  logic [3:0]           dcnt;
  logic                 selected;
  logic                 final_xfer;
  logic                 capture;
  logic                 drop;
  logic [7:0]           shadow_bytes [NB];

  // Byte 0 carries cells 7..0 and is sent first.
  for (genvar b = 0; b < NB; b++) begin : g_bytes
    assign shadow_bytes[b] = shadow[8*b +: 8];
  end

  always_comb begin
    selected   = row_valid && (dcnt == 4'd0);
    final_xfer = (state == SEND) && (idx == LAST_IDX) && out_ready;
    // A row arriving on the final transfer is chained straight in, no gap.
    capture    = selected && ((state == IDLE) || final_xfer);
    drop       = selected && (state == SEND) && !final_xfer;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (capture) begin
          state_nxt = SEND;
          idx_nxt   = '0;
        end
      end
      SEND: begin
        if (capture) begin
          idx_nxt = '0;
        end else if (final_xfer) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else if (out_ready) begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    out_valid = (state == SEND);
    out_data  = out_valid ? shadow_bytes[idx] : 8'h00;
    out_first = out_valid && (idx == '0);
    out_last  = out_valid && (idx == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      dcnt      <= 4'd0;
      shadow    <= '0;
      gen_count <= 16'd0;
      overrun   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (capture) begin
        shadow <= row_in;
      end
      if (row_valid) begin
        gen_count <= gen_count + 16'd1;
        // decim only takes effect when the counter reloads.
        dcnt      <= (dcnt == 4'd0) ? decim : dcnt - 4'd1;
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ca_row_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ca_row_streamer
// Description : Directed self-checking bench for ca_row_streamer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ca_row_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] row_in;
  logic        row_valid;
  logic [3:0]  decim;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_first;
  logic        out_last;
  logic [15:0] gen_count;
  logic        overrun;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] got [$];

  ca_row_streamer #(.NUM_CELLS(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .row_in    (row_in),
    .row_valid (row_valid),
    .decim     (decim),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_first (out_first),
    .out_last  (out_last),
    .gen_count (gen_count),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Record every accepted byte, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) got.push_back(out_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_stream(input string tag, input logic [7:0] exp [$]);
    check({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) check($sformatf("%s_byte%0d", tag, i), {24'h0, got[i]}, {24'h0, exp[i]});
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    row_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    got.delete();
  endtask

  task automatic pulse(input logic [31:0] row);
    row_in    = row;
    row_valid = 1'b1;
    tick();
    row_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    row_in    = 32'h0;
    row_valid = 1'b0;
    decim     = 4'd0;
    out_ready = 1'b1;
    do_reset();

    // Reset state
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_data", {24'h0, out_data}, 32'h0);
    check("rst_first", {31'h0, out_first}, 32'h0);
    check("rst_last", {31'h0, out_last}, 32'h0);
    check("rst_gen", {16'h0, gen_count}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);

    // Basic stream
    pulse(32'hDEADBEEF);
    check("basic_b0", {22'h0, out_valid, out_first, out_last, out_data}, {22'h0, 3'b110, 8'hEF});
    tick();
    check("basic_b1", {22'h0, out_valid, out_first, out_last, out_data}, {22'h0, 3'b100, 8'hBE});
    tick();
    check("basic_b2", {22'h0, out_valid, out_first, out_last, out_data}, {22'h0, 3'b100, 8'hAD});
    tick();
    check("basic_b3", {22'h0, out_valid, out_first, out_last, out_data}, {22'h0, 3'b101, 8'hDE});
    check("basic_gen", {16'h0, gen_count}, 32'd1);
    tick();
    check("basic_idle", {22'h0, out_valid, out_first, out_last, out_data}, 32'h0);
    check_stream("basic", '{8'hEF, 8'hBE, 8'hAD, 8'hDE});

    // Backpressure on byte 1
    got.delete();
    pulse(32'hDEADBEEF);
    check("bp_b0", {24'h0, out_data}, 32'hEF);
    tick();
    check("bp_b1", {24'h0, out_data}, 32'hBE);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_hold%0d", i), {23'h0, out_valid, out_data}, {23'h0, 1'b1, 8'hBE});
    end
    out_ready = 1'b1;
    repeat (4) tick();
    check("bp_idle", {31'h0, out_valid}, 32'h0);
    check_stream("bp", '{8'hEF, 8'hBE, 8'hAD, 8'hDE});

    // Decimation: only rows 1 and 4 selected
    do_reset();
    decim = 4'd2;
    for (int r = 1; r <= 6; r++) begin
      pulse(32'(r));
      repeat (9) tick();
    end
    check("decim_gen", {16'h0, gen_count}, 32'd6);
    check("decim_overrun", {31'h0, overrun}, 32'h0);
    check_stream("decim", '{8'h01, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00});

    // Overrun: B dropped while A is stalled
    do_reset();
    decim     = 4'd0;
    out_ready = 1'b0;
    pulse(32'hA1B2C3D4);
    check("ovr_a0", {23'h0, out_valid, out_data}, {23'h0, 1'b1, 8'hD4});
    tick();
    tick();
    pulse(32'h55667788);
    check("ovr_flag", {31'h0, overrun}, 32'h1);
    check("ovr_hold", {24'h0, out_data}, 32'hD4);
    repeat (3) tick();
    check("ovr_sticky", {31'h0, overrun}, 32'h1);
    out_ready = 1'b1;
    repeat (6) tick();
    check("ovr_idle", {31'h0, out_valid}, 32'h0);
    check("ovr_sticky2", {31'h0, overrun}, 32'h1);
    check_stream("ovr", '{8'hD4, 8'hC3, 8'hB2, 8'hA1});

    // Back-to-back rows, second captured on the final transfer
    do_reset();
    out_ready = 1'b1;
    pulse(32'h11111111);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b2b_valid%0d", i), {31'h0, out_valid}, 32'h1);
      if (i == 3) begin
        row_in    = 32'h22222222;
        row_valid = 1'b1;
      end
      tick();
      row_valid = 1'b0;
    end
    check("b2b_idle", {31'h0, out_valid}, 32'h0);
    check("b2b_overrun", {31'h0, overrun}, 32'h0);
    check_stream("b2b", '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22});

    // Reset mid-frame, coinciding with a row_valid
    do_reset();
    pulse(32'h44332211);
    tick();
    tick();
    check("mid_idx2", {24'h0, out_data}, 32'h33);
    reset     = 1'b1;
    row_in    = 32'h99999999;
    row_valid = 1'b1;
    tick();
    reset     = 1'b0;
    row_valid = 1'b0;
    check("mid_valid", {31'h0, out_valid}, 32'h0);
    check("mid_gen", {16'h0, gen_count}, 32'h0);
    check("mid_overrun", {31'h0, overrun}, 32'h0);
    tick();
    check("mid_still_idle", {31'h0, out_valid}, 32'h0);
    pulse(32'h87654321);
    check("mid_restart", {22'h0, out_valid, out_first, out_last, out_data}, {22'h0, 3'b110, 8'h21});
    repeat (4) tick();

    // Generation counter wrap
    do_reset();
    decim     = 4'd15;
    row_valid = 1'b1;
    repeat (65535) tick();
    check("wrap_ffff", {16'h0, gen_count}, 32'hFFFF);
    tick();
    row_valid = 1'b0;
    check("wrap_zero", {16'h0, gen_count}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
